frost32_mem_responder: RTL and testbench

//  Memory-side responder for the Frost32 CPU data port. Accepts the CPU's request
//  (req_mem_access, addr, data, access type, access size) and services it from a

---
 rtl/frost32_mem_responder.sv | 159 +++++++++++++++
 tb/tb_frost32_mem_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/frost32_mem_responder.sv
// ============================================================================
// Module   : frost32_mem_responder
// Brief    : Fixed-latency, word-organised RAM responder for the Frost32 data port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frost32_mem_responder #(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_mem_access,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        access_type,
  input  logic [1:0]  access_size,
  output logic [31:0] data_out,
  output logic        wait_for_mem,
  output logic        mem_err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] c_CNT_LOAD = CW'(LATENCY - 1);

  localparam logic [1:0] c_DIAS32  = 2'd0;
  localparam logic [1:0] c_DIAS16  = 2'd1;
  localparam logic [1:0] c_DIAS8   = 2'd2;
  localparam logic [1:0] c_DIASBAD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_type;
  logic [1:0]      r_size;
  logic [31:0]     r_dout;
  logic            r_err;

  logic [31:0]     r_mem [MEM_WORDS];

  logic            w_fire;
  logic            w_err;
  logic [AW-1:0]   w_idx;
  logic [4:0]      w_shamt;
  logic [31:0]     w_word;
  logic [31:0]     w_size_mask;
  logic [31:0]     w_rdata;
  logic [31:0]     w_wmask;
  logic [31:0]     w_wdata;
  logic [31:0]     w_newword;
  logic            w_wait;

  assign w_idx   = r_addr[2 +: AW];
  assign w_shamt = {r_addr[1:0], 3'b000};
  assign w_word  = r_mem[w_idx];
  assign w_fire  = (r_state == S_BUSY) && (r_cnt == '0);

  assign w_err = (r_size == c_DIASBAD)
              || ((r_size == c_DIAS32) && (r_addr[1:0] != 2'b00))
              || ((r_size == c_DIAS16) && r_addr[0])
              || (r_addr[31:AW+2] != '0);

  always_comb begin
    w_size_mask = 32'hFFFF_FFFF;
    case (r_size)
      c_DIAS16: w_size_mask = 32'h0000_FFFF;
      c_DIAS8:  w_size_mask = 32'h0000_00FF;
      default:  w_size_mask = 32'hFFFF_FFFF;
    endcase
  end

  // Lane data is aligned to bit 0 for reads and shifted up into place for writes.
  assign w_rdata   = (w_word >> w_shamt) & w_size_mask;
  assign w_wmask   = w_size_mask << w_shamt;
  assign w_wdata   = r_wdata << w_shamt;
  assign w_newword = (w_word & ~w_wmask) | (w_wdata & w_wmask);

  always_comb begin
    w_state_nxt = r_state;
    w_wait      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_wait = req_mem_access;
        if (req_mem_access) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        w_wait = 1'b1;
        if (r_cnt == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_wait      = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_wait      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_type  <= 1'b0;
      r_size  <= 2'b00;
      r_dout  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_fire && w_err;
      if ((r_state == S_IDLE) && req_mem_access) begin
        r_addr  <= addr;
        r_wdata <= data_in;
        r_type  <= access_type;
        r_size  <= access_size;
        r_cnt   <= c_CNT_LOAD;
      end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_fire) begin
        if (w_err)        r_dout <= '0;
        else if (!r_type) r_dout <= w_rdata;
      end
    end
  end

  // RAM has no reset; a reset forces IDLE, so an aborted access never fires.
  always_ff @(posedge clk) begin
    if (w_fire && !w_err && r_type) begin
      r_mem[w_idx] <= w_newword;
    end
  end

  assign data_out     = r_dout;
  assign mem_err      = r_err;
  assign wait_for_mem = w_wait;

endmodule

`default_nettype wire

// File: tb/tb_frost32_mem_responder.sv
// ============================================================================
// Module   : tb_frost32_mem_responder
// Brief    : Randomised self-checking bench against a byte-array memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frost32_mem_responder;

  localparam int MW  = 4096;
  localparam int LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic [31:0] din;
  logic        atype;
  logic [1:0]  asize;
  logic [31:0] dout;
  logic        wfm;
  logic        merr;

  logic        req1;
  logic [31:0] dout1;
  logic        wfm1;
  logic        merr1;

  int vectors;
  int miscompares;

  logic [7:0]  mem_b [4*MW];
  logic [31:0] exp_dout;

  frost32_mem_responder #(.MEM_WORDS(MW), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_mem_access(req), .addr(addr),
    .data_in(din), .access_type(atype), .access_size(asize),
    .data_out(dout), .wait_for_mem(wfm), .mem_err(merr)
  );

  frost32_mem_responder #(.MEM_WORDS(16), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_mem_access(req1), .addr(32'h0000_0004),
    .data_in(32'h1234_5678), .access_type(1'b1), .access_size(2'd0),
    .data_out(dout1), .wait_for_mem(wfm1), .mem_err(merr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic junk_inputs();
    req   = 1'($urandom);
    addr  = $urandom;
    din   = $urandom;
    atype = 1'($urandom);
    asize = 2'($urandom);
  endtask

  // One complete transaction starting just after a rising edge with the DUT idle.
  task automatic access(input logic t, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d);
    logic        e;
    int          nbytes;
    logic [31:0] rv;
    e = (sz == 2'd3) || (sz == 2'd0 && a % 4 != 0) || (sz == 2'd1 && a % 2 != 0)
        || (a >= 32'(4*MW));
    nbytes = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
    if (e) begin
      exp_dout = 32'h0;
    end else if (t) begin
      for (int i = 0; i < nbytes; i++) mem_b[a + i] = d[8*i +: 8];
    end else begin
      rv = 32'h0;
      for (int i = 0; i < nbytes; i++) rv[8*i +: 8] = mem_b[a + i];
      exp_dout = rv;
    end

    req = 1'b1; addr = a; din = d; atype = t; asize = sz;
    @(negedge clk);
    check("wait_idle_req", {31'b0, wfm}, 32'd1);
    @(posedge clk); #1; junk_inputs();
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      check("wait_busy", {31'b0, wfm}, 32'd1);
      check("err_busy", {31'b0, merr}, 32'd0);
      @(posedge clk); #1; junk_inputs();
    end
    @(negedge clk);
    check("wait_done", {31'b0, wfm}, 32'd0);
    check("err_done", {31'b0, merr}, {31'b0, e});
    check("dout_done", dout, exp_dout);
    @(posedge clk); #1; req = 1'b0;
    @(negedge clk);
    check("err_after", {31'b0, merr}, 32'd0);
    check("wait_after", {31'b0, wfm}, 32'd0);
    check("dout_hold", dout, exp_dout);
    @(posedge clk); #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    exp_dout = 32'h0;
    rst_n = 1'b0; req = 1'b0; req1 = 1'b0;
    addr = 32'h0; din = 32'h0; atype = 1'b0; asize = 2'd0;

    @(posedge clk); #2;
    check("rst_dout", dout, 32'h0);
    check("rst_wait", {31'b0, wfm}, 32'd0);
    check("rst_err", {31'b0, merr}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    for (int w = 0; w < 64; w++) access(1'b1, 2'd0, 32'(w*4), $urandom);

    access(1'b1, 2'd0, 32'h10, 32'hDEAD_BEEF);
    access(1'b0, 2'd0, 32'h10, 32'h0);
    access(1'b1, 2'd0, 32'h10, 32'h1122_3344);
    access(1'b1, 2'd2, 32'h13, 32'hFFFF_FFAA);
    access(1'b0, 2'd0, 32'h10, 32'h0);
    access(1'b0, 2'd2, 32'h13, 32'h0);
    access(1'b1, 2'd1, 32'h12, 32'h5555_BEEF);
    access(1'b0, 2'd1, 32'h12, 32'h0);
    access(1'b0, 2'd0, 32'h10, 32'h0);
    access(1'b0, 2'd0, 32'h11, 32'h0);
    access(1'b0, 2'd0, 32'h10, 32'h0);
    access(1'b1, 2'd3, 32'h0, 32'hFFFF_FFFF);
    access(1'b0, 2'd0, 32'h0, 32'h0);
    access(1'b1, 2'd0, 32'(4*MW), 32'hCAFE_F00D);
    access(1'b0, 2'd2, 32'(4*MW), 32'h0);
    access(1'b1, 2'd1, 32'h21, 32'h0000_1234);
    access(1'b0, 2'd0, 32'h20, 32'h0);

    // Reset during the first BUSY cycle must abort the write.
    req = 1'b1; addr = 32'h20; din = 32'h0BAD_0BAD; atype = 1'b1; asize = 2'd0;
    @(posedge clk); #1; req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("rstbusy_dout", dout, 32'h0);
    check("rstbusy_wait", {31'b0, wfm}, 32'd0);
    check("rstbusy_err", {31'b0, merr}, 32'd0);
    exp_dout = 32'h0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 2'd0, 32'h20, 32'h0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      if ($urandom_range(7) == 0) a = 32'(4*MW) + $urandom_range(255);
      else                        a = $urandom_range(255);
      access(1'($urandom), 2'($urandom), a, $urandom);
    end

    // LATENCY=1 instance with request held high: accepts every third cycle.
    req1 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("l1_wait", {31'b0, wfm1}, (i % 3 == 2) ? 32'd0 : 32'd1);
      check("l1_err", {31'b0, merr1}, 32'd0);
      check("l1_dout", dout1, 32'h0);
      @(posedge clk); #1;
    end
    req1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
